// File: rtl/pair_cutoff_buffer.sv
// pair_cutoff_buffer: exact r2 cutoff filter feeding a FIFO toward the force
// evaluator. Accepted pairs are queued in order; upstream is throttled through
// a registered stall, and accept/reject statistics are kept.
module pair_cutoff_buffer #(
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int ID_WIDTH          = 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CUTOFF_2 = 32'h3F800000,
  parameter int FIFO_DEPTH        = 64,
  parameter int FIFO_ADDR_WIDTH   = 6,
  parameter int STALL_THRESHOLD   = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_r2,
  input  logic [DATA_WIDTH-1:0]      in_dx,
  input  logic [DATA_WIDTH-1:0]      in_dy,
  input  logic [DATA_WIDTH-1:0]      in_dz,
  input  logic [ID_WIDTH-1:0]        in_nb_id,
  input  logic [3*CELL_ID_WIDTH-1:0] in_ref_cell_id,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_r2,
  output logic [DATA_WIDTH-1:0]      out_dx,
  output logic [DATA_WIDTH-1:0]      out_dy,
  output logic [DATA_WIDTH-1:0]      out_dz,
  output logic [ID_WIDTH-1:0]        out_nb_id,
  output logic [3*CELL_ID_WIDTH-1:0] out_ref_cell_id,
  output logic                       stall,
  output logic                       overflow,
  input  logic                       count_clear,
  output logic [31:0]                accepted_count,
  output logic [31:0]                rejected_count
);

  localparam int RW = 3*CELL_ID_WIDTH;
  localparam int EW = RW + ID_WIDTH + 4*DATA_WIDTH;
  localparam int AW = FIFO_ADDR_WIDTH;
  localparam int UW = FIFO_ADDR_WIDTH + 1;
  localparam logic [UW-1:0] DEPTH_U  = UW'(FIFO_DEPTH);
  localparam logic [UW-1:0] THRESH_U = UW'(STALL_THRESHOLD);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);

  // Positive-float ordering matches unsigned ordering of the magnitude bits,
  // so the cutoff test is an integer compare once the sign bit is excluded.
  logic in_accept;
  assign in_accept = in_valid & ~in_r2[DATA_WIDTH-1] &
                     (in_r2[DATA_WIDTH-2:0] != '0) &
                     (in_r2[DATA_WIDTH-2:0] < CUTOFF_2[DATA_WIDTH-2:0]);

  logic          s1_valid;
  logic          s1_accept;
  logic [EW-1:0] s1_entry;

  // Stage 1: input register, loaded unconditionally every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_accept <= 1'b0;
      s1_entry  <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_accept <= in_accept;
      s1_entry  <= {in_ref_cell_id, in_nb_id, in_dz, in_dy, in_dx, in_r2};
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [UW-1:0] used;
  logic [UW-1:0] used_next;
  logic          pop;
  logic          wr_req;
  logic          wr_en;
  logic          drop;
  logic [EW-1:0] head;

  assign out_valid = (used != '0);
  assign pop       = out_valid & out_ready;
  assign wr_req    = s1_valid & s1_accept;
  // A simultaneous pop frees a slot, so a full FIFO still takes the write.
  assign wr_en     = wr_req & ((used < DEPTH_U) | pop);
  assign drop      = wr_req & ~wr_en;
  assign head      = mem[rd_ptr];

  assign {out_ref_cell_id, out_nb_id, out_dz, out_dy, out_dx, out_r2} =
    out_valid ? head : '0;

  function automatic logic [AW-1:0] advance(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  // Occupancy after this edge.
  always_comb begin
    used_next = used;
    if (wr_en && !pop) used_next = used + UW'(1);
    else if (!wr_en && pop) used_next = used - UW'(1);
  end

  // FIFO storage; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s1_entry;
  end

  // FIFO pointers, occupancy, stall and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      used     <= '0;
      stall    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (pop)   rd_ptr <= advance(rd_ptr);
      if (wr_en) wr_ptr <= advance(wr_ptr);
      used  <= used_next;
      stall <= (used_next >= THRESH_U);
      if (drop) overflow <= 1'b1;
    end
  end

  // Accept/reject statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepted_count <= '0;
      rejected_count <= '0;
    end else if (count_clear) begin
      accepted_count <= '0;
      rejected_count <= '0;
    end else begin
      if (wr_en) accepted_count <= accepted_count + 32'd1;
      if (s1_valid && !s1_accept) rejected_count <= rejected_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_pair_cutoff_buffer.sv
// Bench for pair_cutoff_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_pair_cutoff_buffer;

  localparam int DW = 32;
  localparam int CW = 3;
  localparam int IW = 3*CW + 7;
  localparam int RW = 3*CW;
  localparam int EW = RW + IW + 4*DW;

  typedef logic [EW-1:0] entry_t;
  typedef struct { int cyc; entry_t e; } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_r2 = '0, in_dx = '0, in_dy = '0, in_dz = '0;
  logic [IW-1:0] in_nb_id = '0;
  logic [RW-1:0] in_ref_cell_id = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_r2, out_dx, out_dy, out_dz;
  logic [IW-1:0] out_nb_id;
  logic [RW-1:0] out_ref_cell_id;
  logic          stall, overflow;
  logic          count_clear = 1'b0;
  logic [31:0]   accepted_count, rejected_count;

  pair_cutoff_buffer #(
    .DATA_WIDTH(DW), .CELL_ID_WIDTH(CW), .PARTICLE_ID_WIDTH(7), .ID_WIDTH(IW),
    .CUTOFF_2(32'h3F800000), .FIFO_DEPTH(64), .FIFO_ADDR_WIDTH(6),
    .STALL_THRESHOLD(40)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r2(in_r2), .in_dx(in_dx),
    .in_dy(in_dy), .in_dz(in_dz), .in_nb_id(in_nb_id),
    .in_ref_cell_id(in_ref_cell_id), .out_ready(out_ready),
    .out_valid(out_valid), .out_r2(out_r2), .out_dx(out_dx), .out_dy(out_dy),
    .out_dz(out_dz), .out_nb_id(out_nb_id), .out_ref_cell_id(out_ref_cell_id),
    .stall(stall), .overflow(overflow), .count_clear(count_clear),
    .accepted_count(accepted_count), .rejected_count(rejected_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  entry_t dut_e;
  assign dut_e = {out_ref_cell_id, out_nb_id, out_dz, out_dy, out_dx, out_r2};

  task automatic chk1(input string n, input logic a, input logic e);
    total++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0b expected %0b (t=%0t)", n, a, e, $time);
  endtask

  task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
  endtask

  task automatic chke(input string n, input entry_t a, input entry_t e);
    total++;
    if (a === e) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
  endtask

  // Distinct payload per pair index so ordering and field integrity are visible.
  function automatic entry_t mk(input int i, input logic [31:0] r2);
    logic [31:0]   dx, dy, dz;
    logic [IW-1:0] nb;
    logic [RW-1:0] rf;
    dx = 32'h4000_0000 + 32'(i);
    dy = 32'(i) * 32'd3;
    dz = ~32'(i);
    nb = IW'(i) ^ 16'hA5A5;
    rf = RW'(i);
    return {rf, nb, dz, dy, dx, r2};
  endfunction

  // Exact cutoff rule: strictly positive and strictly below rc^2 = 1.0f.
  function automatic bit passes_cutoff(input logic [31:0] r2);
    return (r2[31] == 1'b0) && (r2 != 32'd0) && (r2 < 32'h3F80_0000);
  endfunction

  // ---------------- reference model ----------------
  entry_t      mq[$];
  logic        pend_v = 1'b0;
  entry_t      pend = '0;
  logic [31:0] m_acc = '0, m_rej = '0;
  logic        m_ovf = 1'b0, m_stall = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit          do_pop, room;
    logic [31:0] na, nr;
    logic        no;
    if (rst) begin
      mq.delete();
      pend_v  <= 1'b0;
      m_acc   <= '0;
      m_rej   <= '0;
      m_ovf   <= 1'b0;
      m_stall <= 1'b0;
    end else begin
      na = m_acc; nr = m_rej; no = m_ovf;
      do_pop = (mq.size() != 0) && out_ready;
      room   = (mq.size() < 64) || do_pop;
      if (do_pop) mq.delete(0);
      if (pend_v) begin
        if (passes_cutoff(pend[31:0])) begin
          if (room) begin mq.push_back(pend); na = na + 32'd1; end
          else no = 1'b1;
        end else begin
          nr = nr + 32'd1;
        end
      end
      if (count_clear) begin na = '0; nr = '0; end
      m_acc   <= na;
      m_rej   <= nr;
      m_ovf   <= no;
      m_stall <= (mq.size() >= 40);
      pend_v  <= in_valid;
      pend    <= {in_ref_cell_id, in_nb_id, in_dz, in_dy, in_dx, in_r2};
    end
  end

  // ---------------- per-cycle compare ----------------
  obs_t seen[$];
  int   rises[$];
  int   falls[$];
  logic prev_stall = 1'b0;

  always @(negedge clk) begin
    entry_t exp_e;
    exp_e = (mq.size() != 0) ? mq[0] : '0;
    chk1 ("out_valid", out_valid, mq.size() != 0);
    chke ("out_data", dut_e, exp_e);
    chk1 ("stall", stall, m_stall);
    chk1 ("overflow", overflow, m_ovf);
    chk32("accepted_count", accepted_count, m_acc);
    chk32("rejected_count", rejected_count, m_rej);
    if (out_valid && out_ready) seen.push_back('{cyc: cyc, e: dut_e});
    if (stall && !prev_stall) rises.push_back(cyc);
    if (!stall && prev_stall) falls.push_back(cyc);
    prev_stall <= stall;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input entry_t e);
    in_valid = 1'b1;
    {in_ref_cell_id, in_nb_id, in_dz, in_dy, in_dx, in_r2} = e;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n0, n40, m, base;

    // Async reset with no clock edge yet.
    #1 rst = 1'b1;
    #1;
    chk1 ("rst_out_valid", out_valid, 1'b0);
    chk1 ("rst_stall", stall, 1'b0);
    chk1 ("rst_overflow", overflow, 1'b0);
    chk32("rst_acc", accepted_count, 32'd0);
    chk32("rst_rej", rejected_count, 32'd0);
    chk32("rst_out_r2", out_r2, 32'd0);
    step(); step();
    rst = 1'b0;
    idle(2);

    // Cutoff boundary: only entries 1 and 5 survive.
    out_ready = 1'b1;
    base = seen.size();
    n0 = cyc;
    push(mk(1, 32'h3F7F_FFFF));
    push(mk(2, 32'h3F80_0000));
    push(mk(3, 32'h0000_0000));
    push(mk(4, 32'h8000_0000));
    push(mk(5, 32'h3E80_0000));
    idle(4);
    chk32("cut_n_out", 32'(seen.size() - base), 32'd2);
    if (seen.size() - base >= 2) begin
      chke ("cut_e1", seen[base].e, mk(1, 32'h3F7F_FFFF));
      chk32("cut_lat1", 32'(seen[base].cyc), 32'(n0 + 2));
      chke ("cut_e5", seen[base+1].e, mk(5, 32'h3E80_0000));
      chk32("cut_lat5", 32'(seen[base+1].cyc), 32'(n0 + 6));
    end
    chk32("cut_acc", accepted_count, 32'd2);
    chk32("cut_rej", rejected_count, 32'd3);

    // Backpressure hold, then back-to-back drain.
    out_ready = 1'b0;
    base = seen.size();
    for (int i = 1; i <= 5; i++) push(mk(10 + i, 32'h3E80_0000 + 32'(i)));
    in_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk1("hold_valid", out_valid, 1'b1);
      chke("hold_head", dut_e, mk(11, 32'h3E80_0001));
      step();
    end
    out_ready = 1'b1;
    idle(8);
    chk32("bp_n_out", 32'(seen.size() - base), 32'd5);
    if (seen.size() - base >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chke ("bp_order", seen[base+k].e, mk(11 + k, 32'h3E80_0001 + 32'(k)));
        chk32("bp_consec", 32'(seen[base+k].cyc), 32'(seen[base].cyc + k));
      end
    end

    // Stall threshold: rises two cycles after the 40th pair enters.
    out_ready = 1'b0;
    n40 = 0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 40) n40 = cyc;
      push(mk(100 + i, 32'h3E80_0000 + 32'(i)));
    end
    idle(3);
    chk1 ("stall_high", stall, 1'b1);
    chk32("stall_rises", 32'(rises.size()), 32'd1);
    chk32("stall_rise_cyc", (rises.size() > 0) ? 32'(rises[0]) : 32'hFFFF_FFFF, 32'(n40 + 2));
    m = cyc;
    out_ready = 1'b1;
    idle(50);
    chk32("stall_falls", 32'(falls.size()), 32'd1);
    chk32("stall_fall_cyc", (falls.size() > 0) ? 32'(falls[0]) : 32'hFFFF_FFFF, 32'(m + 6));

    // count_clear alongside an accepted write.
    count_clear = 1'b1;
    push(mk(200, 32'h3E80_0000));
    idle(1);
    count_clear = 1'b0;
    @(negedge clk);
    chk32("clr_acc", accepted_count, 32'd0);
    chk32("clr_rej", rejected_count, 32'd0);
    chk1 ("clr_entry_kept", out_valid, 1'b1);
    step();
    idle(3);

    // Overflow: 66 pairs into 64 slots.
    out_ready = 1'b0;
    base = seen.size();
    for (int i = 1; i <= 66; i++) push(mk(300 + i, 32'h3E80_0000 + 32'(i)));
    idle(3);
    chk1 ("ovf_set", overflow, 1'b1);
    chk32("ovf_acc", accepted_count, 32'd64);
    out_ready = 1'b1;
    idle(70);
    chk32("ovf_n_out", 32'(seen.size() - base), 32'd64);
    if (seen.size() - base >= 64)
      for (int k = 0; k < 64; k++)
        chke("ovf_order", seen[base+k].e, mk(301 + k, 32'h3E80_0001 + 32'(k)));

    // Async reset mid-stream with 10 entries stored.
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) push(mk(250 + i, 32'h3E80_0000 + 32'(i)));
    idle(3);
    #2 rst = 1'b1;
    #1;
    chk1 ("mid_rst_valid", out_valid, 1'b0);
    chk1 ("mid_rst_stall", stall, 1'b0);
    chk1 ("mid_rst_ovf", overflow, 1'b0);
    chk32("mid_rst_acc", accepted_count, 32'd0);
    chk32("mid_rst_rej", rejected_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    base = seen.size();
    n0 = cyc;
    push(mk(500, 32'h3E90_0000));
    idle(4);
    chk32("post_rst_n", 32'(seen.size() - base), 32'd1);
    if (seen.size() - base >= 1) begin
      chk32("post_rst_lat", 32'(seen[base].cyc), 32'(n0 + 2));
      chke ("post_rst_e", seen[base].e, mk(500, 32'h3E90_0000));
    end

    // At full, a same-cycle push and pop is legal.
    out_ready = 1'b0;
    base = seen.size();
    for (int i = 1; i <= 65; i++) push(mk(400 + i, 32'h3E80_0000 + 32'(i)));
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    idle(2);
    chk1 ("full_pp_ovf", overflow, 1'b0);
    chk32("full_pp_acc", accepted_count, 32'd66);
    push(mk(466, 32'h3E80_0042));
    idle(3);
    chk1 ("full_drop_ovf", overflow, 1'b1);
    chk32("full_drop_acc", accepted_count, 32'd66);
    out_ready = 1'b1;
    idle(70);
    chk32("full_n_out", 32'(seen.size() - base), 32'd65);
    if (seen.size() - base >= 65)
      for (int k = 0; k < 65; k++)
        chke("full_order", seen[base+k].e, mk(401 + k, 32'h3E80_0001 + 32'(k)));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/pair_cutoff_buffer.md
# pair_cutoff_buffer

Sits directly downstream of the filter bank in each MD pipeline. Takes the filter bank's float r², dx/dy/dz, neighbour ID and reference cell ID stream and applies the exact cutoff test (0 < r² < rc²). Surviving pairs go into a FIFO that feeds the force evaluator over a valid/ready handshake. Drives an early stall back to the filter arbiter control and keeps accept/reject statistics.

## Interface
- DATA_WIDTH, 32, float width of r2/dx/dy/dz
- CELL_ID_WIDTH, 3, per-axis cell ID width
- PARTICLE_ID_WIDTH, 7, particle ID width
- ID_WIDTH, 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH, neighbour ID width
- CUTOFF_2, 32'h3F800000, rc² in IEEE-754 single (positive)
- FIFO_DEPTH, 64, entries
- FIFO_ADDR_WIDTH, 6, log2(FIFO_DEPTH)
- STALL_THRESHOLD, 40, occupancy at which stall asserts
- clk  in  1  single clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  filter bank out_valid
- in_r2, in_dx, in_dy, in_dz  in  DATA_WIDTH each  filter bank outputs
- in_nb_id  in  ID_WIDTH  {z,y,x cell, particle ID}
- in_ref_cell_id  in  3*CELL_ID_WIDTH  {Z,Y,X}
- out_ready  in  1  force evaluator can take a pair
- out_valid  out  1  head entry valid
- out_r2, out_dx, out_dy, out_dz  out  DATA_WIDTH each  head entry
- out_nb_id  out  ID_WIDTH; out_ref_cell_id  out  3*CELL_ID_WIDTH
- stall  out  1  registered; gates the filter arbiter upstream
- overflow  out  1  sticky; a pair was dropped because the FIFO was full
- count_clear  in  1  synchronous clear of both counters
- accepted_count, rejected_count  out  32 each  wrapping pair counters

## Operation
- Stage 1 is an input register, loaded every cycle. It captures in_valid and all fields. The accept flag is computed here.
- accept = in_valid & ~r2[31] & (r2[30:0] != 0) & (r2[30:0] < CUTOFF_2[30:0]).
  - This is an unsigned integer compare, which is valid for positive floats.
  - A sign bit set, including -0.0, rejects the pair.
  - +0.0 (self-pair) rejects.
  - r2 == CUTOFF_2 rejects.
- Stage 2 writes the FIFO when the stage-1 entry is valid and accepted.
- Write is legal when used < FIFO_DEPTH, or when a pop occurs in the same cycle.
- Otherwise the entry is dropped, overflow sets, and accepted_count does not increment.
- Entry layout is {ref_cell_id, nb_id, dz, dy, dx, r2}. FIFO order is preserved.
- Pop occurs when out_valid & out_ready. The out_* fields show the head entry and are held stable while out_valid=1 and out_ready=0.
- used:
  - +1 on write only, -1 on pop only, unchanged on both or neither.
  - Pointers wrap modulo FIFO_DEPTH.
- stall is registered: stall <= (used_next >= STALL_THRESHOLD). The threshold leaves 24 slots for filter bank in-flight pairs (about 19 cycles of pipeline).
- Counters:
  - accepted_count increments per written entry.
  - rejected_count increments per stage-1 entry that is valid and not accepted.
  - Both wrap at 2^32.
  - count_clear has priority over an increment in the same cycle.
- overflow clears only on rst.

## Timing
- Reset (async assert): out_valid=0, all out_* data=0, stall=0, overflow=0, counters=0, FIFO empty, stage 1 invalid. Outputs are defined immediately, with no clock needed.
- Latency: a pair presented with in_valid in cycle N gives out_valid=1 in cycle N+2 if the FIFO was empty. A simultaneous pop on an empty FIFO does not bypass.
- Throughput is 1 pair per cycle in and out.
- stall follows the occupancy change by 1 cycle.
- Reset asserted mid-stream discards all stored and in-flight pairs. No output handshake completes in the reset cycle.

## Test plan
- Cutoff boundary:
  - Stimulus: r2 = 0x3F7FFFFF, 0x3F800000, 0x00000000, 0x80000000, 0x3E800000, with out_ready=1.
  - Required: exactly entries 1 and 5 appear, in that order, each 2 cycles after input, with dx/dy/dz/IDs intact.
  - Required: accepted_count=2, rejected_count=3.
- Backpressure hold:
  - Stimulus: 5 accepted pairs, out_ready=0 for 10 cycles, then 1.
  - Required: out_* hold entry 1 with no change during the wait, then entries 1..5 drain on consecutive cycles.
- Stall threshold:
  - Stimulus: out_ready=0, stream accepted pairs.
  - Required: stall rises the cycle after the 40th write and falls the cycle after used drops to 39.
- Full/overflow:
  - Stimulus: out_ready=0, 66 accepted pairs.
  - Required: used=64, overflow=1, accepted_count=64, and the drained FIFO holds pairs 1..64.
  - Stimulus: at full, push and pop in the same cycle.
  - Required: the push is accepted and no overflow occurs.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges with 10 entries stored.
  - Required: out_valid, stall and counters go to 0 immediately.
  - Required: after release, the first new pair emerges at N+2.
- count_clear with a simultaneous accepted pair → both counters read 0 the next cycle.
